// File: rtl/hyperram_rx_capture.sv
// HyperRAM read-data receive path: RWDS-qualified word capture, burst counting and a show-ahead FIFO.
// Define HRX_TIMEOUT_EN to compile in the missing-RWDS watchdog and its abort path.
module hyperram_rx_capture #(
  parameter int FIFO_AW = 4,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [7:0]       dq_rise,
  input  logic [7:0]       dq_fall,
  input  logic             rwds_rise,
  input  logic             rwds_fall,
  output logic [15:0]      rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic             err_overflow
);
  localparam int DEPTH = 1 << FIFO_AW;

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("hyperram_rx_capture: TIMEOUT must be >= 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CAPTURE, S_DRAIN, S_DONE} state_t;

  state_t             state, state_nx;
  logic [LEN_W-1:0]   remaining;
  logic               active, ws, ws_acc, start_ok, last_word, timeout_hit;
  logic               in_valid;
  logic [15:0]        in_word;
  logic [15:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               empty, full, push, pop, drop;

  assign ws        = rwds_rise & ~rwds_fall;
  assign active    = (state == S_WAIT) || (state == S_CAPTURE);
  assign ws_acc    = active & ws;
  assign start_ok  = start & (state == S_IDLE);
  assign last_word = (remaining == LEN_W'(1));

  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    // NOTE: default assigned first so no branch leaves state_nx unassigned (no latch).
    state_nx = state;
    case (state)
      S_IDLE:             if (start) state_nx = (burst_len == '0) ? S_DONE : S_WAIT;
      S_WAIT, S_CAPTURE: begin
        if (ws_acc)           state_nx = last_word ? S_DRAIN : S_CAPTURE;
        else if (timeout_hit) state_nx = S_DRAIN;
      end
      S_DRAIN:            state_nx = S_DONE;
      S_DONE:             state_nx = S_IDLE;
      default:            state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)           remaining <= '0;
    else if (start_ok) remaining <= burst_len;
    else if (ws_acc)   remaining <= remaining - LEN_W'(1);
  end

`ifdef HRX_TIMEOUT_EN
  // Counter only needs to reach TIMEOUT-1; the abort fires on the next strobe-less cycle.
  localparam int WD_W = $clog2(TIMEOUT);
  logic [WD_W-1:0] wd_cnt;
  logic            err_timeout_q;

  assign timeout_hit = active & ~ws & (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      wd_cnt        <= '0;
      err_timeout_q <= 1'b0;
    end else if (active) begin
      if (ws)               wd_cnt <= '0;
      else if (timeout_hit) err_timeout_q <= 1'b1;
      else                  wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid <= 1'b0;
      in_word  <= '0;
    end else begin
      in_valid <= ws_acc;
      if (ws_acc) in_word <= {dq_rise, dq_fall};
    end
  end

  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign empty = (count == '0);
  assign full  = (count == (FIFO_AW + 1)'(DEPTH));
  assign pop   = ~empty & rd_ready;
  assign push  = in_valid & (~full | pop);
  assign drop  = in_valid & full & ~pop;

  always_ff @(posedge clk) begin
    // NOTE: storage array is not reset; the empty flag masks stale contents.
    if (push) mem[wr_ptr] <= in_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW + 1)'(1);
        2'b01:   count <= count - (FIFO_AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start_ok) err_overflow <= 1'b0;
    else if (drop)       err_overflow <= 1'b1;
  end

  assign rd_valid = ~empty;
  assign rd_data  = empty ? 16'h0000 : mem[rd_ptr];
  assign busy     = active;
  assign done     = (state == S_DONE);

endmodule

// File: tb/tb_hyperram_rx_capture.sv
// Self-checking bench for hyperram_rx_capture: directed scenarios plus random traffic against a queue-based model.
module tb_hyperram_rx_capture;
  localparam int FIFO_AW = 2;
  localparam int LEN_W   = 16;
  localparam int TIMEOUT = 8;
  localparam int DEPTH   = 1 << FIFO_AW;
`ifdef HRX_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] burst_len = '0;
  logic [7:0]       dq_rise = '0;
  logic [7:0]       dq_fall = '0;
  logic             rwds_rise = 1'b0;
  logic             rwds_fall = 1'b0;
  logic             rd_ready = 1'b0;
  logic [15:0]      rd_data;
  logic             rd_valid, busy, done, err_timeout, err_overflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hyperram_rx_capture #(.FIFO_AW(FIFO_AW), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
    .dq_rise(dq_rise), .dq_fall(dq_fall), .rwds_rise(rwds_rise), .rwds_fall(rwds_fall),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .err_timeout(err_timeout), .err_overflow(err_overflow)
  );

  wire [20:0] obs = {rd_valid, rd_data, busy, done, err_timeout, err_overflow};

  // Behavioural model: burst bookkeeping in integers, FIFO as a bounded queue,
  // one pending word for the capture register.
  logic [15:0] m_q[$];
  logic [15:0] m_stage;
  bit          m_stage_v, m_active, m_drain, m_done, m_ovf, m_tmo;
  int          m_rem, m_idle;

  function automatic logic [20:0] exp_vec();
    logic [15:0] head;
    head = (m_q.size() > 0) ? m_q[0] : 16'h0000;
    return {m_q.size() > 0, head, m_active, m_done, m_tmo, m_ovf};
  endfunction

  task automatic model_step();
    bit pop, ws, was_idle;
    if (rst) begin
      m_q.delete();
      m_stage_v = 0; m_active = 0; m_drain = 0; m_done = 0;
      m_ovf = 0; m_tmo = 0; m_rem = 0; m_idle = 0;
      return;
    end
    was_idle = !m_active && !m_drain && !m_done;
    pop = (m_q.size() > 0) && rd_ready;
    if (pop) void'(m_q.pop_front());
    if (m_stage_v) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_stage);
      else                    m_ovf = 1;
    end
    m_stage_v = 0;
    ws = rwds_rise && !rwds_fall;
    m_done  = m_drain;
    m_drain = 0;
    if (m_active) begin
      if (ws) begin
        m_stage_v = 1;
        m_stage   = {dq_rise, dq_fall};
        m_idle    = 0;
        m_rem--;
        if (m_rem == 0) begin m_active = 0; m_drain = 1; end
      end else begin
        m_idle++;
        if (TMO_EN && m_idle >= TIMEOUT) begin m_tmo = 1; m_active = 0; m_drain = 1; end
      end
    end else if (was_idle && start) begin
      m_ovf = 0; m_tmo = 0; m_idle = 0;
      if (burst_len == '0) m_done = 1;
      else begin m_active = 1; m_rem = int'(burst_len); end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input bit s, input int len, input bit stb, input logic [15:0] w, input bit rdy);
    start     = s;
    burst_len = LEN_W'(len);
    rwds_rise = stb;
    rwds_fall = 1'b0;
    {dq_rise, dq_fall} = w;
    rd_ready  = rdy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 16'h0, 0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    if (rd_data !== 16'h0)    begin failures++; $display("FAIL reset_rd_data got=%h exp=0000", rd_data); end
    checks++;
    if (rd_valid !== 1'b0)    begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++;
    if (busy !== 1'b0)        begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (done !== 1'b0)        begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++;
    if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err_timeout got=%b exp=0", err_timeout); end
    checks++;
    if (err_overflow !== 1'b0) begin failures++; $display("FAIL reset_err_overflow got=%b exp=0", err_overflow); end
    checks++;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] words [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    logic [15:0] got[$];
    int n_done = 0;
    for (int c = 0; c < 10; c++) begin
      set_in(c == 0, 4, (c >= 1 && c <= 4), (c >= 1 && c <= 4) ? words[c-1] : 16'($urandom), 1);
      @(negedge clk);
      if (obs !== exp_vec()) begin failures++; $display("FAIL basic cyc%0d got=%h exp=%h", c, obs, exp_vec()); end
      checks++;
      if (done) n_done++;
      if (rd_valid && rd_ready) got.push_back(rd_data);
      next_cycle();
    end
    if (n_done != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", n_done); end
    checks++;
    if (got.size() != 4) begin failures++; $display("FAIL basic_word_count got=%0d exp=4", got.size()); end
    checks++;
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      if (got[i] !== words[i]) begin failures++; $display("FAIL basic_word%0d got=%h exp=%h", i, got[i], words[i]); end
      checks++;
    end
  endtask

  task automatic test_zero_len();
    int n_done = 0;
    int n_busy = 0;
    int n_valid = 0;
    for (int c = 0; c < 4; c++) begin
      set_in(c == 0, 0, 0, 16'($urandom), 1);
      @(negedge clk);
      if (obs !== exp_vec()) begin failures++; $display("FAIL zero_len cyc%0d got=%h exp=%h", c, obs, exp_vec()); end
      checks++;
      if (c == 1 && done !== 1'b1) begin failures++; $display("FAIL zero_len_done_cyc1 got=%b exp=1", done); end
      if (c == 1) checks++;
      n_done += int'(done);
      n_busy += int'(busy);
      n_valid += int'(rd_valid);
      next_cycle();
    end
    if (n_done != 1 || n_busy != 0 || n_valid != 0) begin
      failures++;
      $display("FAIL zero_len_summary got done=%0d busy=%0d valid=%0d exp 1/0/0", n_done, n_busy, n_valid);
    end
    checks++;
  endtask

  task automatic test_overflow();
    logic [15:0] words [6];
    logic [15:0] got[$];
    foreach (words[i]) words[i] = 16'($urandom);
    for (int c = 0; c < 10; c++) begin
      set_in(c == 0, 6, (c >= 1 && c <= 6), (c >= 1 && c <= 6) ? words[c-1] : 16'h0, 0);
      @(negedge clk);
      if (obs !== exp_vec()) begin failures++; $display("FAIL overflow cyc%0d got=%h exp=%h", c, obs, exp_vec()); end
      checks++;
      next_cycle();
    end
    if (err_overflow !== 1'b1) begin failures++; $display("FAIL overflow_flag got=%b exp=1", err_overflow); end
    checks++;
    for (int c = 0; c < 6; c++) begin
      set_in(0, 0, 0, 16'h0, 1);
      @(negedge clk);
      if (obs !== exp_vec()) begin failures++; $display("FAIL overflow_drain cyc%0d got=%h exp=%h", c, obs, exp_vec()); end
      checks++;
      if (rd_valid) got.push_back(rd_data);
      next_cycle();
    end
    if (got.size() != 4) begin failures++; $display("FAIL overflow_kept got=%0d exp=4", got.size()); end
    checks++;
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      if (got[i] !== words[i]) begin failures++; $display("FAIL overflow_word%0d got=%h exp=%h", i, got[i], words[i]); end
      checks++;
    end
  endtask

  task automatic test_full_pop();
    logic [15:0] words [7];
    logic [15:0] got[$];
    foreach (words[i]) words[i] = 16'($urandom);
    for (int c = 0; c < 8; c++) begin
      set_in(c == 0, 4, (c >= 1 && c <= 4), (c >= 1 && c <= 4) ? words[c-1] : 16'h0, 0);
      @(negedge clk);
      if (obs !== exp_vec()) begin failures++; $display("FAIL full_fill cyc%0d got=%h exp=%h", c, obs, exp_vec()); end
      checks++;
      next_cycle();
    end
    for (int c = 0; c < 12; c++) begin
      set_in(c == 0, 3, (c >= 1 && c <= 3), (c >= 1 && c <= 3) ? words[c+3] : 16'h0, c >= 2);
      @(negedge clk);
      if (obs !== exp_vec()) begin failures++; $display("FAIL full_pop cyc%0d got=%h exp=%h", c, obs, exp_vec()); end
      checks++;
      if (rd_valid && rd_ready) got.push_back(rd_data);
      next_cycle();
    end
    if (err_overflow !== 1'b0) begin failures++; $display("FAIL full_pop_flag got=%b exp=0", err_overflow); end
    checks++;
    if (got.size() != 7) begin failures++; $display("FAIL full_pop_count got=%0d exp=7", got.size()); end
    checks++;
    for (int i = 0; i < 7 && i < got.size(); i++) begin
      if (got[i] !== words[i]) begin failures++; $display("FAIL full_pop_word%0d got=%h exp=%h", i, got[i], words[i]); end
      checks++;
    end
  endtask

  task automatic test_timeout();
    logic [15:0] words [2];
    logic [15:0] got[$];
    int n_done = 0;
    foreach (words[i]) words[i] = 16'($urandom);
    for (int c = 0; c < 16; c++) begin
      set_in(c == 0, 4, (c == 1 || c == 2), (c == 1 || c == 2) ? words[c-1] : 16'h0, 0);
      @(negedge clk);
      if (obs !== exp_vec()) begin failures++; $display("FAIL timeout cyc%0d got=%h exp=%h", c, obs, exp_vec()); end
      checks++;
      n_done += int'(done);
      next_cycle();
    end
    if (err_timeout !== 1'b1 || n_done != 1) begin
      failures++;
      $display("FAIL timeout_abort got err=%b done=%0d exp err=1 done=1", err_timeout, n_done);
    end
    checks++;
    for (int c = 0; c < 4; c++) begin
      set_in(0, 0, 0, 16'h0, 1);
      @(negedge clk);
      if (rd_valid) got.push_back(rd_data);
      next_cycle();
    end
    if (got.size() != 2 || got[0] !== words[0] || got[1] !== words[1]) begin
      failures++;
      $display("FAIL timeout_words got_count=%0d exp=2 (%h %h)", got.size(), words[0], words[1]);
    end
    checks++;
    for (int c = 0; c < 6; c++) begin
      set_in(c == 0, 1, c == 1, 16'($urandom), 1);
      @(negedge clk);
      if (c == 1 && err_timeout !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%b exp=0", err_timeout); end
      if (c == 1) checks++;
      if (obs !== exp_vec()) begin failures++; $display("FAIL timeout_restart cyc%0d got=%h exp=%h", c, obs, exp_vec()); end
      checks++;
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] words [2];
    logic [15:0] got[$];
    int n_done = 0;
    foreach (words[i]) words[i] = 16'($urandom);
    for (int c = 0; c < 14; c++) begin
      rst = (c == 4);
      set_in(c == 0, 8, (c >= 1 && c <= 3), 16'($urandom), 0);
      @(negedge clk);
      if (c == 5 && (rd_valid !== 1'b0 || busy !== 1'b0)) begin
        failures++;
        $display("FAIL reset_mid_flush got valid=%b busy=%b exp 0/0", rd_valid, busy);
      end
      if (c == 5) checks++;
      if (obs !== exp_vec()) begin failures++; $display("FAIL reset_mid cyc%0d got=%h exp=%h", c, obs, exp_vec()); end
      checks++;
      if (c >= 5) n_done += int'(done);
      next_cycle();
    end
    rst = 1'b0;
    if (n_done != 0) begin failures++; $display("FAIL reset_mid_done got=%0d exp=0", n_done); end
    checks++;
    for (int c = 0; c < 10; c++) begin
      set_in(c == 0, 2, (c == 1 || c == 2), (c == 1 || c == 2) ? words[c-1] : 16'h0, 1);
      @(negedge clk);
      if (obs !== exp_vec()) begin failures++; $display("FAIL reset_mid_new cyc%0d got=%h exp=%h", c, obs, exp_vec()); end
      checks++;
      if (rd_valid && rd_ready) got.push_back(rd_data);
      next_cycle();
    end
    if (got.size() != 2 || got[0] !== words[0] || got[1] !== words[1]) begin
      failures++;
      $display("FAIL reset_mid_words got_count=%0d exp=2 (%h %h)", got.size(), words[0], words[1]);
    end
    checks++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      start     = ($urandom_range(0, 19) == 0);
      burst_len = LEN_W'($urandom_range(0, 7));
      rwds_rise = ($urandom_range(0, 4) != 0);
      rwds_fall = ($urandom_range(0, 3) == 0);
      {dq_rise, dq_fall} = 16'($urandom);
      rd_ready  = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      if (obs !== exp_vec()) begin failures++; $display("FAIL random cyc%0d got=%h exp=%h", c, obs, exp_vec()); end
      checks++;
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_overflow();
    test_full_pop();
`ifdef HRX_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
